// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared types, widths and the round-robin pick function for the
//          I-cache / D-cache backing-memory port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    // Arbiter FSM encoding: plain constants so older tools can consume them.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_BUSY = 2'd1;
    localparam arb_state_t ARB_DONE = 2'd2;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    // One captured memory transaction.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  read;
        logic                  write;
        logic [ARB_LINE_W-1:0] wdata;
    } arb_req_t;

    // Single requester wins outright; a tie goes to whoever was not served last.
    function automatic arb_src_t arb_pick(input logic i_req, input logic d_req,
                                          input arb_src_t last);
        arb_src_t pick;
        if (i_req && d_req) begin
            pick = (last == SRC_I) ? SRC_D : SRC_I;
        end else if (d_req) begin
            pick = SRC_D;
        end else begin
            pick = SRC_I;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Line-granular DFP handshake bundle (addr/read/write/wdata forward,
//          rdata/resp back). Used for both cache sides and the memory side.
//          master : issues requests (cache, or arbiter toward memory)
//          slave  : serves requests (arbiter toward caches, or memory)
// Rev    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (
        output addr, read, write, wdata,
        input  rdata, resp
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one backing-memory DFP port between the I-cache and the
//          D-cache. One whole transaction is granted at a time, ties are
//          round-robin, the request is registered, and the single memory
//          completion pulse is routed to the granted cache.
// Ports  : clk    - clock, all state on posedge
//          rst    - asynchronous active-high reset
//          i_dfp  - I-cache side (slave); read-only requester
//          d_dfp  - D-cache side (slave); fill and writeback requester
//          dfp    - memory side (master)
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   i_dfp,
    mem_port_arbiter_if.slave   d_dfp,
    mem_port_arbiter_if.master  dfp
);

    arb_state_t state_q, state_d;
    arb_src_t   last_grant_q, last_grant_d;
    arb_req_t   held_q, held_d;

    logic w_i_req;
    logic w_d_req;
    logic w_busy;
    logic w_resp_ok;
    logic w_unused_i_write;

    assign w_i_req = i_dfp.read;
    assign w_d_req = d_dfp.read | d_dfp.write;

    // The I-cache never writes; its write-side signals are deliberately ignored.
    assign w_unused_i_write = i_dfp.write ^ (^i_dfp.wdata);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        held_d       = held_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_i_req || w_d_req) begin
                    last_grant_d = arb_pick(w_i_req, w_d_req, last_grant_q);
                    if (last_grant_d == SRC_I) begin
                        held_d.addr  = ARB_ADDR_W'(i_dfp.addr);
                        held_d.read  = 1'b1;
                        held_d.write = 1'b0;
                        held_d.wdata = '0;
                    end else begin
                        // Write wins if the D-cache ever raises both strobes.
                        held_d.addr  = ARB_ADDR_W'(d_dfp.addr);
                        held_d.read  = d_dfp.read & ~d_dfp.write;
                        held_d.write = d_dfp.write;
                        held_d.wdata = ARB_LINE_W'(d_dfp.wdata);
                    end
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (dfp.resp) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                // Bubble: the cache is still dropping the request it just had served.
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= SRC_D;
            held_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            held_q       <= held_d;
        end
    end

    assign w_busy    = (state_q == ARB_BUSY);
    assign w_resp_ok = w_busy & dfp.resp;

    // Memory side comes only from the held copy, so requester churn is invisible.
    assign dfp.addr  = ADDR_W'(held_q.addr);
    assign dfp.wdata = LINE_W'(held_q.wdata);
    assign dfp.read  = w_busy & held_q.read;
    assign dfp.write = w_busy & held_q.write;

    assign i_dfp.resp  = w_resp_ok & (last_grant_q == SRC_I);
    assign d_dfp.resp  = w_resp_ok & (last_grant_q == SRC_D);
    assign i_dfp.rdata = i_dfp.resp ? dfp.rdata : '0;
    assign d_dfp.rdata = d_dfp.resp ? dfp.rdata : '0;

    a_resp_only_when_busy : assert property (@(posedge clk) disable iff (rst)
        !(dfp.resp && !w_busy));

    a_single_strobe : assert property (@(posedge clk) disable iff (rst)
        !(dfp.read && dfp.write));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench for mem_port_arbiter. Directed scenarios
//          followed by randomized transactions, compared against a
//          transaction-level model of who should be served and with what.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(256)) i_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(256)) d_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(256)) m_if ();

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(256)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .i_dfp (i_if),
        .d_dfp (d_if),
        .dfp   (m_if)
    );

    always #5 clk = ~clk;

    int vec         = 0;
    int miscompares = 0;

    // Transaction-level model: what each cache is asking for, and who was served last.
    bit            exp_last_d;
    bit            i_pend, d_pend, d_wr, d_both;
    logic [31:0]   i_addr, d_addr;
    logic [255:0]  d_wdata;
    bit            grants[$];

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        return $urandom() & 32'hFFFF_FFE0;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("one_strobe", 256'(m_if.read & m_if.write), 256'd0);
    endtask

    task automatic drive();
        i_if.addr  = i_addr;
        i_if.read  = i_pend;
        i_if.write = 1'b0;
        i_if.wdata = '0;
        d_if.addr  = d_addr;
        d_if.read  = d_pend & (!d_wr | d_both);
        d_if.write = d_pend & d_wr;
        d_if.wdata = d_wdata;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        i_pend = 0;
        d_pend = 0;
        d_both = 0;
        drive();
        m_if.resp  = 1'b0;
        m_if.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_last_d = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"}, 256'({m_if.read, m_if.write}), 256'd0);
        check({tag, "_resps"},   256'({i_if.resp, d_if.resp}),  256'd0);
    endtask

    // Caller guarantees we are in an idle cycle with at least one request driven.
    task automatic do_txn(input int lat, input logic [255:0] rd, input bit hold,
                          input bit pert, input logic [31:0] pert_addr, input bit drop);
        bit           g_d;
        bit           ew;
        logic [31:0]  ea;
        logic [255:0] ewd;
        g_d = (i_pend && d_pend) ? !exp_last_d : d_pend;
        ea  = g_d ? d_addr : i_addr;
        ew  = g_d & d_wr;
        ewd = d_wdata;
        step();
        exp_last_d = g_d;
        grants.push_back(g_d);
        check("strobe_read",  256'(m_if.read),  256'(!ew));
        check("strobe_write", 256'(m_if.write), 256'(ew));
        check("addr",         256'(m_if.addr),  256'(ea));
        if (ew) check("wdata", m_if.wdata, ewd);
        if (pert) begin
            if (g_d) d_if.addr = pert_addr; else i_if.addr = pert_addr;
        end
        if (drop) begin
            if (g_d) begin d_if.read = 1'b0; d_if.write = 1'b0; end
            else i_if.read = 1'b0;
        end
        for (int k = 0; k < lat; k++) begin
            step();
            check("held_addr",   256'(m_if.addr), 256'(ea));
            check("held_strobe", 256'({m_if.read, m_if.write}), 256'({!ew, ew}));
            check("early_resp",  256'({i_if.resp, d_if.resp}), 256'd0);
        end
        m_if.rdata = rd;
        m_if.resp  = 1'b1;
        #1;
        check("i_resp", 256'(i_if.resp), 256'(!g_d));
        check("d_resp", 256'(d_if.resp), 256'(g_d));
        if (!ew) check("rdata_granted", g_d ? d_if.rdata : i_if.rdata, rd);
        check("rdata_other", g_d ? i_if.rdata : d_if.rdata, 256'd0);
        step();
        m_if.resp  = 1'b0;
        m_if.rdata = '0;
        if (g_d) d_pend = 0; else i_pend = 0;
        if (!hold) drive();
        check_quiet("done");
        step();
        check_quiet("idle");
        if (hold) drive();
    endtask

    task automatic new_i();
        i_pend = 1;
        i_addr = rand_addr();
    endtask

    task automatic new_d();
        d_pend  = 1;
        d_addr  = rand_addr();
        d_wr    = $urandom_range(0, 1);
        d_both  = d_wr && ($urandom_range(0, 3) == 0);
        d_wdata = rand_line();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_addr  = '0;
        d_addr  = '0;
        d_wr    = 0;
        d_wdata = '0;
        rst     = 1'b1;
        i_pend  = 0;
        d_pend  = 0;
        d_both  = 0;
        drive();
        m_if.resp  = 1'b0;
        m_if.rdata = '0;
        @(posedge clk);
        #1;
        check("rst_addr",  256'(m_if.addr), 256'd0);
        check("rst_wdata", m_if.wdata, 256'd0);
        check_quiet("rst");
        check("rst_rdata", i_if.rdata | d_if.rdata, 256'd0);
        do_reset();

        // I read alone, memory answers five cycles after the strobe.
        i_pend = 1; i_addr = 32'h0000_0040;
        drive();
        do_txn(5, {32{8'hA5}}, 0, 0, '0, 0);

        // Reset in the middle of a D writeback drops the strobe at once, no resp.
        do_reset();
        d_pend = 1; d_wr = 1; d_addr = 32'h0000_1000; d_wdata = rand_line();
        drive();
        step();
        check("pre_rst_write", 256'(m_if.write), 256'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_drops_write", 256'(m_if.write), 256'd0);
        m_if.resp = 1'b1;
        #1;
        check("rst_no_d_resp", 256'(d_if.resp), 256'd0);
        @(posedge clk);
        #1;
        m_if.resp = 1'b0;
        rst = 1'b0;
        exp_last_d = 1'b1;

        // Simultaneous I read and D write after reset: I first, D write intact after.
        grants.delete();
        i_pend = 1; i_addr = 32'h0000_0080;
        drive();
        do_txn(2, rand_line(), 0, 0, '0, 0);
        do_txn(3, rand_line(), 0, 0, '0, 0);
        check("tie_order", 256'({grants[0], grants[1]}), 256'(2'b01));

        // D moves its address while busy: memory keeps the captured one.
        d_pend = 1; d_wr = 0; d_both = 0; d_addr = 32'h0000_2000;
        drive();
        do_txn(4, rand_line(), 0, 1, 32'h0000_3000, 0);

        // D keeps its read up one cycle past resp: no second transaction.
        d_pend = 1; d_wr = 0; d_addr = 32'h0000_4000;
        drive();
        do_txn(2, rand_line(), 1, 0, '0, 0);
        step();
        check_quiet("no_repeat");
        step();
        check_quiet("no_repeat2");

        // Back-to-back: a waiting D strobes right after the done/idle gap of I.
        i_pend = 1; i_addr = 32'h0000_6000;
        d_pend = 1; d_wr = 0; d_addr = 32'h0000_7000;
        drive();
        do_txn(1, rand_line(), 0, 0, '0, 0);
        do_txn(0, rand_line(), 0, 0, '0, 1);

        // Both requesting continuously: strict alternation starting with I.
        do_reset();
        grants.delete();
        new_i();
        new_d();
        for (int k = 0; k < 8; k++) begin
            drive();
            do_txn($urandom_range(0, 3), rand_line(), 0, 0, '0, 0);
            if (grants[k]) new_d(); else new_i();
        end
        for (int k = 0; k < 8; k++) check("alternate", 256'(grants[k]), 256'(k % 2));

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) new_i();
            if (!d_pend && $urandom_range(0, 1) == 1) new_d();
            if (!i_pend && !d_pend) new_i();
            drive();
            do_txn($urandom_range(0, 5), rand_line(), 0,
                   $urandom_range(0, 1), rand_addr(), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
